hazard_stall_controller: RTL and testbench

Pipeline sequencing controller for the 5-stage RISC-V core. Owns the PC/IF-ID/ID-EX write enables, the flush/bubble controls and the multi-cycle mul/div unit (MDU) start/wait handshake. It complements the EX-stage forwarding logic by handling the hazards forwarding cannot resolve: load-use, taken branches and multi-cycle EX operations. Sits in the hazard path between the ID/EX/MEM pipeline registers and the MDU.

---
 rtl/hazard_stall_controller.sv | 111 +++++++++++
 tb/tb_hazard_stall_controller.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/hazard_stall_controller.sv
// Pipeline hazard controller: load-use stalls, taken-branch flushes and the
// multi-cycle MDU start/wait handshake with timeout abort.
module hazard_stall_controller #(
  parameter int MDU_TIMEOUT = 64,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       IFID_rs1,
  input  logic [4:0]       IFID_rs2,
  input  logic             IFID_uses_rs1,
  input  logic             IFID_uses_rs2,
  input  logic [4:0]       IDEX_rd,
  input  logic             IDEX_MemRead,
  input  logic             IDEX_is_muldiv,
  input  logic             EX_branch_taken,
  input  logic             mdu_done,
  output logic             PC_write,
  output logic             IFID_write,
  output logic             IDEX_write,
  output logic             IFID_flush,
  output logic             IDEX_flush,
  output logic             EXMEM_bubble,
  output logic             mdu_start,
  output logic             mdu_error,
  output logic [CNT_W-1:0] stall_count
);

  localparam int WAIT_W = (MDU_TIMEOUT > 1) ? $clog2(MDU_TIMEOUT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MDU_TIMEOUT - 1);

  typedef enum logic {RUN, MDU_WAIT} state_t;

  state_t            state;
  state_t            state_next;
  logic [WAIT_W-1:0] wait_cnt;
  logic [WAIT_W-1:0] wait_next;
  logic              set_error;
  logic              load_use;

  // Register x0 never carries a real dependency, so a load to x0 cannot stall.
  assign load_use = IDEX_MemRead && (IDEX_rd != 5'd0) &&
                    ((IFID_uses_rs1 && (IDEX_rd == IFID_rs1)) ||
                     (IFID_uses_rs2 && (IDEX_rd == IFID_rs2)));

  always_comb begin
    PC_write     = 1'b1;
    IFID_write   = 1'b1;
    IDEX_write   = 1'b1;
    IFID_flush   = 1'b0;
    IDEX_flush   = 1'b0;
    EXMEM_bubble = 1'b0;
    mdu_start    = 1'b0;
    state_next   = state;
    wait_next    = wait_cnt;
    set_error    = 1'b0;
    case (state)
      RUN: begin
        if (EX_branch_taken) begin
          IFID_flush = 1'b1;
          IDEX_flush = 1'b1;
        end else if (IDEX_is_muldiv) begin
          mdu_start    = 1'b1;
          PC_write     = 1'b0;
          IFID_write   = 1'b0;
          IDEX_write   = 1'b0;
          EXMEM_bubble = 1'b1;
          state_next   = MDU_WAIT;
          wait_next    = '0;
        end else if (load_use) begin
          PC_write   = 1'b0;
          IFID_write = 1'b0;
          IDEX_flush = 1'b1;
        end
      end
      MDU_WAIT: begin
        // A done on the last allowed cycle still counts as a normal completion.
        if (mdu_done) begin
          state_next = RUN;
        end else if (wait_cnt == WAIT_LAST) begin
          EXMEM_bubble = 1'b1;
          set_error    = 1'b1;
          state_next   = RUN;
        end else begin
          PC_write     = 1'b0;
          IFID_write   = 1'b0;
          IDEX_write   = 1'b0;
          EXMEM_bubble = 1'b1;
          wait_next    = wait_cnt + WAIT_W'(1);
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= RUN;
      wait_cnt    <= '0;
      mdu_error   <= 1'b0;
      stall_count <= '0;
    end else begin
      state    <= state_next;
      wait_cnt <= wait_next;
      if (set_error)
        mdu_error <= 1'b1;
      if (!PC_write && (stall_count != '1))
        stall_count <= stall_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_hazard_stall_controller.sv
// Scoreboard bench for hazard_stall_controller: directed vectors push expected
// outputs, a negedge monitor pops and compares them.
module tb_hazard_stall_controller;

  logic       clk;
  logic       rst_n;
  logic [4:0] IFID_rs1, IFID_rs2, IDEX_rd;
  logic       IFID_uses_rs1, IFID_uses_rs2;
  logic       IDEX_MemRead, IDEX_is_muldiv, EX_branch_taken, mdu_done;
  logic       PC_write, IFID_write, IDEX_write, IFID_flush, IDEX_flush;
  logic       EXMEM_bubble, mdu_start, mdu_error;
  logic [3:0] stall_count;

  int assertCount = 0;
  int failCount   = 0;

  string      nameQ[$];
  logic [11:0] expQ[$];

  // Flag order: {PC_write,IFID_write,IDEX_write,IFID_flush,IDEX_flush,EXMEM_bubble,mdu_start,mdu_error}
  localparam logic [7:0] RUN_OK   = 8'b1110_0000;
  localparam logic [7:0] RUN_ERR  = 8'b1110_0001;
  localparam logic [7:0] LU_STALL = 8'b0010_1000;
  localparam logic [7:0] LU_ERR   = 8'b0010_1001;
  localparam logic [7:0] BR_FLUSH = 8'b1111_1000;
  localparam logic [7:0] START    = 8'b0000_0110;
  localparam logic [7:0] START_E  = 8'b0000_0111;
  localparam logic [7:0] WAITING  = 8'b0000_0100;
  localparam logic [7:0] WAIT_E   = 8'b0000_0101;
  localparam logic [7:0] ABORT    = 8'b1110_0100;

  hazard_stall_controller #(.MDU_TIMEOUT(8), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .IFID_rs1(IFID_rs1), .IFID_rs2(IFID_rs2),
    .IFID_uses_rs1(IFID_uses_rs1), .IFID_uses_rs2(IFID_uses_rs2),
    .IDEX_rd(IDEX_rd), .IDEX_MemRead(IDEX_MemRead),
    .IDEX_is_muldiv(IDEX_is_muldiv), .EX_branch_taken(EX_branch_taken),
    .mdu_done(mdu_done),
    .PC_write(PC_write), .IFID_write(IFID_write), .IDEX_write(IDEX_write),
    .IFID_flush(IFID_flush), .IDEX_flush(IDEX_flush),
    .EXMEM_bubble(EXMEM_bubble), .mdu_start(mdu_start),
    .mdu_error(mdu_error), .stall_count(stall_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drives one cycle of inputs just after the rising edge and queues the
  // outputs expected while those inputs are held.
  task automatic applyStimulus(input string name, input logic rst, input logic mr,
                               input logic [4:0] rd, input logic [4:0] rs1, input logic u1,
                               input logic [4:0] rs2, input logic u2, input logic md,
                               input logic br, input logic dn,
                               input logic [7:0] eflags, input logic [3:0] ecnt);
    @(posedge clk);
    #1;
    rst_n           = rst;
    IDEX_MemRead    = mr;
    IDEX_rd         = rd;
    IFID_rs1        = rs1;
    IFID_uses_rs1   = u1;
    IFID_rs2        = rs2;
    IFID_uses_rs2   = u2;
    IDEX_is_muldiv  = md;
    EX_branch_taken = br;
    mdu_done        = dn;
    nameQ.push_back(name);
    expQ.push_back({eflags, ecnt});
  endtask

  task automatic idle(input string name, input logic dn,
                      input logic [7:0] eflags, input logic [3:0] ecnt);
    applyStimulus(name, 1'b1, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, dn, eflags, ecnt);
  endtask

  task automatic mduCycle(input string name, input logic br, input logic dn,
                          input logic [7:0] eflags, input logic [3:0] ecnt);
    applyStimulus(name, 1'b1, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, br, dn, eflags, ecnt);
  endtask

  task automatic checkOutput();
    string       name;
    logic [11:0] expv;
    logic [11:0] act;
    name = nameQ.pop_front();
    expv = expQ.pop_front();
    act  = {PC_write, IFID_write, IDEX_write, IFID_flush, IDEX_flush,
            EXMEM_bubble, mdu_start, mdu_error, stall_count};
    assertCount++;
    if (act !== expv) begin
      failCount++;
      $display("[TB] FAIL %s: got flags=%b cnt=%0d, expected flags=%b cnt=%0d",
               name, act[11:4], act[3:0], expv[11:4], expv[3:0]);
    end
  endtask

  always @(negedge clk) begin
    if (expQ.size() > 0)
      checkOutput();
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_n = 1'b0; IDEX_MemRead = 1'b0; IDEX_rd = 5'd0; IFID_rs1 = 5'd0; IFID_rs2 = 5'd0;
    IFID_uses_rs1 = 1'b0; IFID_uses_rs2 = 1'b0; IDEX_is_muldiv = 1'b0;
    EX_branch_taken = 1'b0; mdu_done = 1'b0;

    applyStimulus("reset", 1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, RUN_OK, 4'd0);
    idle("idle_after_reset", 1'b0, RUN_OK, 4'd0);

    // Load-use hazards and their non-stalling look-alikes
    applyStimulus("load_use_rs2", 1'b1, 1'b1, 5'd5, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, LU_STALL, 4'd0);
    idle("after_load_use", 1'b0, RUN_OK, 4'd1);
    applyStimulus("load_rd_x0", 1'b1, 1'b1, 5'd0, 5'd0, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, RUN_OK, 4'd1);
    applyStimulus("rs_unused", 1'b1, 1'b1, 5'd5, 5'd5, 1'b0, 5'd5, 1'b0, 1'b0, 1'b0, 1'b0, RUN_OK, 4'd1);
    applyStimulus("load_use_rs1", 1'b1, 1'b1, 5'd7, 5'd7, 1'b1, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0, LU_STALL, 4'd1);

    // Branch outranks load-use and muldiv
    applyStimulus("branch_over_lu", 1'b1, 1'b1, 5'd7, 5'd7, 1'b1, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, BR_FLUSH, 4'd2);
    mduCycle("branch_over_mdu", 1'b1, 1'b0, BR_FLUSH, 4'd2);
    idle("after_branch", 1'b0, RUN_OK, 4'd2);

    // MDU op, done four cycles after start; branch and load-use ignored while waiting
    mduCycle("mdu_start", 1'b0, 1'b0, START, 4'd2);
    mduCycle("mdu_wait1", 1'b0, 1'b0, WAITING, 4'd3);
    mduCycle("mdu_wait2_br", 1'b1, 1'b0, WAITING, 4'd4);
    applyStimulus("mdu_wait3_lu", 1'b1, 1'b1, 5'd7, 5'd7, 1'b1, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, WAITING, 4'd5);
    mduCycle("mdu_done", 1'b0, 1'b1, RUN_OK, 4'd6);
    idle("after_mdu", 1'b0, RUN_OK, 4'd6);
    idle("done_in_run", 1'b1, RUN_OK, 4'd6);

    // Done on the final timeout cycle completes normally
    mduCycle("late_start", 1'b0, 1'b0, START, 4'd6);
    for (int i = 1; i <= 7; i++)
      mduCycle($sformatf("late_wait%0d", i), 1'b0, 1'b0, WAITING, 4'(6 + i));
    mduCycle("late_done", 1'b0, 1'b1, RUN_OK, 4'd14);
    idle("after_late_done", 1'b0, RUN_OK, 4'd14);

    // Timeout abort; stall_count also saturates at 15 here
    mduCycle("to_start", 1'b0, 1'b0, START, 4'd14);
    for (int i = 1; i <= 7; i++)
      mduCycle($sformatf("to_wait%0d", i), 1'b0, 1'b0, WAITING, 4'd15);
    mduCycle("to_abort", 1'b0, 1'b0, ABORT, 4'd15);
    idle("error_sticky", 1'b0, RUN_ERR, 4'd15);
    idle("error_stray_done", 1'b1, RUN_ERR, 4'd15);
    applyStimulus("error_lu_sat", 1'b1, 1'b1, 5'd9, 5'd0, 1'b0, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0, LU_ERR, 4'd15);

    // Asynchronous reset in the middle of an MDU wait
    mduCycle("rst_mdu_start", 1'b0, 1'b0, START_E, 4'd15);
    mduCycle("rst_mdu_wait", 1'b0, 1'b0, WAIT_E, 4'd15);
    applyStimulus("reset_mid_wait", 1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, RUN_OK, 4'd0);
    idle("late_done_ignored", 1'b1, RUN_OK, 4'd0);
    applyStimulus("lu_after_reset", 1'b1, 1'b1, 5'd4, 5'd4, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, LU_STALL, 4'd0);
    idle("count_after_reset", 1'b0, RUN_OK, 4'd1);

    for (int i = 0; i < 10 && expQ.size() > 0; i++)
      @(posedge clk);
    if (expQ.size() > 0) begin
      assertCount++;
      failCount++;
      $display("[TB] FAIL drain: got %0d unchecked entries, expected 0", expQ.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
